// File: rtl/control_padding_reader_if.sv
// control_padding_reader_if
//   Bundles the two buses of the padding reader:
//     - padding-buffer read port : rd_en, rd_addr (reader -> buffer),
//                                  rd_data (buffer -> reader, 1-cycle latency)
//     - window output stream     : data_out, valid_out, last_out (reader -> PE array),
//                                  ready_in (PE array -> reader)
//   master = the reader, slave = the buffer/consumer side.
interface control_padding_reader_if #(
  parameter int PE = 16
);
  logic              rd_en;
  logic [31:0]       rd_addr;
  logic [PE*8-1:0]   rd_data;
  logic [PE*8-1:0]   data_out;
  logic              valid_out;
  logic              ready_in;
  logic              last_out;

  modport master (
    output rd_en, rd_addr, data_out, valid_out, last_out,
    input  rd_data, ready_in
  );

  modport slave (
    input  rd_en, rd_addr, data_out, valid_out, last_out,
    output rd_data, ready_in
  );
endinterface

// File: rtl/control_padding_reader.sv
// control_padding_reader
//   Streams a zero-padded feature map out of the padding buffer as 3x3
//   convolution windows. Words leave in (oy, ox, ky, kx, cw) order; each word
//   is fetched from the buffer with the same layout the padding writer uses.
//   Reading overlaps writing: output row oy is only fetched once the writer
//   has reported at least oy+3 committed padded rows.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse, samples IFM_C / IFM_W / padding when idle
//   IFM_C       channel count (multiple of PE)
//   IFM_W       feature-map width (= height)
//   padding     pad width, 0 or 1
//   row_done    writer pulse: one more padded row is committed
//   bus         master side of control_padding_reader_if
//                 buffer read port (rd_en/rd_addr/rd_data) and
//                 window stream (data_out/valid_out/ready_in/last_out)
//   busy        high while a stream is in progress
//   done        one-cycle pulse after the final word is accepted
module control_padding_reader #(
  parameter int PE        = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 IFM_C,
  input  logic [7:0]                 IFM_W,
  input  logic                       padding,
  input  logic                       row_done,
  control_padding_reader_if.master   bus,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = PE * 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;

  // geometry latched at start
  logic [8:0]      pw_q, pw_d;          // padded width
  logic [8:0]      ow_q, ow_d;          // output width (PW - 2)
  logic [7:0]      cw_q, cw_d;          // buffer words per pixel
  logic            skip_q, skip_d;      // nothing to stream for this config

  // stream position of the next read
  logic [8:0]      oy_q, oy_d;
  logic [8:0]      ox_q, ox_d;
  logic [1:0]      ky_q, ky_d;
  logic [1:0]      kx_q, kx_d;
  logic [7:0]      cwc_q, cwc_d;

  // rows the writer has committed
  logic [8:0]      rows_q, rows_d;

  // read in flight (issued last cycle, data lands this cycle)
  logic            infl_q, infl_d;
  logic            infl_last_q, infl_last_d;

  // 2-entry output FIFO
  logic [DW-1:0]   mem_q [2];
  logic [DW-1:0]   mem_d [2];
  logic [1:0]      lastm_q, lastm_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  // registered status outputs
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [8:0]      pw_live;
  logic [7:0]      cw_live;
  logic [8:0]      rows_cap;
  logic            pop;
  logic [2:0]      credit;
  logic            rows_ok;
  logic            last_pos;
  logic            issue;
  logic [31:0]     win_row;
  logic [31:0]     win_col;
  logic [31:0]     pix;
  logic [31:0]     addr;

  always_comb begin
    pw_live  = 9'(IFM_W) + (padding ? 9'd2 : 9'd0);
    cw_live  = 8'(IFM_C / 8'(PE));

    // Before a stream is configured the writer may already be filling rows
    // for it, so the saturation limit follows the live configuration.
    rows_cap = (state_q == S_IDLE) ? pw_live : pw_q;

    pop      = (count_q != 2'd0) && bus.ready_in;

    // Slots committed to the FIFO once this cycle's pop is accounted for.
    // Counting the pop lets a read go out every cycle while the consumer
    // keeps up, yet never lets occupancy exceed two entries under stall.
    credit   = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};

    rows_ok  = {1'b0, rows_q} >= ({1'b0, oy_q} + 10'd3);

    last_pos = (oy_q == ow_q - 9'd1) && (ox_q == ow_q - 9'd1) &&
               (ky_q == 2'd2) && (kx_q == 2'd2) &&
               (cwc_q == cw_q - 8'd1);

    issue    = (state_q == S_READ) && !skip_q && rows_ok && (credit < 3'd2);

    win_row  = 32'(oy_q) + 32'(ky_q);
    win_col  = 32'(ox_q) + 32'(kx_q);
    pix      = win_row * 32'(pw_q) + win_col;
    addr     = (pix * 32'(cw_q) + 32'(cwc_q)) * 32'(ADDR_STEP);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    ow_d        = ow_q;
    cw_d        = cw_q;
    skip_d      = skip_q;
    oy_d        = oy_q;
    ox_d        = ox_q;
    ky_d        = ky_q;
    kx_d        = kx_q;
    cwc_d       = cwc_q;
    rows_d      = rows_q;
    infl_d      = issue;
    infl_last_d = issue && last_pos;
    mem_d       = mem_q;
    lastm_d     = lastm_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // row availability
    if (state_q == S_DONE) begin
      rows_d = row_done ? 9'd1 : 9'd0;
    end else if (row_done && (rows_q < rows_cap)) begin
      rows_d = rows_q + 9'd1;
    end

    // FIFO: write the word returned for last cycle's read, pop on accept
    if (infl_q) begin
      mem_d[wr_ptr_q]   = bus.rd_data;
      lastm_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, infl_q} - {1'b0, pop};

    // stream position advance, innermost cw first
    if (issue) begin
      if (cwc_q == cw_q - 8'd1) begin
        cwc_d = 8'd0;
        if (kx_q == 2'd2) begin
          kx_d = 2'd0;
          if (ky_q == 2'd2) begin
            ky_d = 2'd0;
            if (ox_q == ow_q - 9'd1) begin
              ox_d = 9'd0;
              oy_d = oy_q + 9'd1;
            end else begin
              ox_d = ox_q + 9'd1;
            end
          end else begin
            ky_d = ky_q + 2'd1;
          end
        end else begin
          kx_d = kx_q + 2'd1;
        end
      end else begin
        cwc_d = cwc_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pw_d    = pw_live;
          ow_d    = pw_live - 9'd2;
          cw_d    = cw_live;
          // A zero channel-word count would never reach the final word,
          // so it is treated like a too-small padded width.
          skip_d  = (pw_live < 9'd3) || (cw_live == 8'd0);
          oy_d    = 9'd0;
          ox_d    = 9'd0;
          ky_d    = 2'd0;
          kx_d    = 2'd0;
          cwc_d   = 8'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // An empty stream still spends one cycle here so that done lands
        // two cycles after start, with busy covering the cycle between.
        if (skip_q) begin
          state_d = S_DONE;
        end else if (issue && last_pos) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && lastm_q[rd_ptr_q]) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pw_q        <= 9'd0;
      ow_q        <= 9'd0;
      cw_q        <= 8'd0;
      skip_q      <= 1'b0;
      oy_q        <= 9'd0;
      ox_q        <= 9'd0;
      ky_q        <= 2'd0;
      kx_q        <= 2'd0;
      cwc_q       <= 8'd0;
      rows_q      <= 9'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      lastm_q     <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      ow_q        <= ow_d;
      cw_q        <= cw_d;
      skip_q      <= skip_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      cwc_q       <= cwc_d;
      rows_q      <= rows_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      lastm_q     <= lastm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr;
  assign bus.data_out  = mem_q[rd_ptr_q];
  assign bus.valid_out = (count_q != 2'd0);
  assign bus.last_out  = (count_q != 2'd0) && lastm_q[rd_ptr_q];
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_control_padding_reader.sv
// Testbench for control_padding_reader: random buffer contents keyed by
// address, expected window stream built from the address formula, and a
// negedge monitor that pops the scoreboard on every accepted beat.
module tb_control_padding_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  IFM_C;
  logic [7:0]  IFM_W;
  logic        padding;
  logic        row_done;
  logic        busy;
  logic        done;

  control_padding_reader_if #(.PE(16)) bus ();

  control_padding_reader #(.PE(16), .ADDR_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .IFM_C    (IFM_C),
    .IFM_W    (IFM_W),
    .padding  (padding),
    .row_done (row_done),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rows_total = 0;
  int rows_base = 0;
  int ready_mode = 0;          // 0: always 1, 1: random, 2: held low
  logic [31:0] salt = 32'h1234_5678;

  logic [127:0] exp_data[$];
  bit           exp_last[$];
  int           exp_addr[$];
  int           exp_oy[$];

  int beats = 0;
  int first_acc = -1;
  int last_acc = -1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [127:0] word_of(input logic [31:0] a);
    return {a ^ salt, a * 32'h9E37_79B1, ~a, a + salt};
  endfunction

  // buffer model: 1-cycle read latency, garbage when not read
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? word_of(bus.rd_addr) : {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (row_done) rows_total <= rows_total + 1;
  end

  // ready driver
  initial begin
    bus.ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.ready_in = 1'b1;
        1:       bus.ready_in = 1'($urandom_range(0, 1));
        default: bus.ready_in = 1'b0;
      endcase
    end
  end

  // monitor
  bit           stall_prev = 0;
  logic [127:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", bus.valid_out, 1);
        chk("stall_data", bus.data_out, held);
      end
      stall_prev = bus.valid_out && !bus.ready_in;
      held = bus.data_out;

      if (bus.rd_en) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got rd_addr %0h expected no read (cycle %0d)", bus.rd_addr, cyc);
        end else begin
          int ea, eoy;
          ea = exp_addr.pop_front();
          eoy = exp_oy.pop_front();
          chk("rd_addr", bus.rd_addr, 32'(ea));
          chk("row_gate", ((rows_total - rows_base) >= eoy + 3), 1);
        end
      end

      if (bus.valid_out && bus.ready_in) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", bus.data_out, cyc);
        end else begin
          logic [127:0] ed;
          bit el;
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          chk("data_out", bus.data_out, ed);
          chk("last_out", bus.last_out, el);
          $display("beat %0d cycle %0d data %0h last %0b", beats, cyc, bus.data_out, bus.last_out);
        end
        beats++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  // reference stream from the address formula
  function automatic int build_exp(input int c, input int w, input int p);
    int pw, ow, cwn, total, idx, a;
    pw = w + 2 * p;
    cwn = c / 16;
    ow = pw - 2;
    exp_data.delete(); exp_last.delete(); exp_addr.delete(); exp_oy.delete();
    if (pw < 3) return 0;
    total = ow * ow * 9 * cwn;
    idx = 0;
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            for (int cc = 0; cc < cwn; cc++) begin
              a = (((oy + ky) * pw + (ox + kx)) * cwn + cc) * 4;
              exp_data.push_back(word_of(32'(a)));
              exp_last.push_back(idx == total - 1);
              exp_addr.push_back(a);
              exp_oy.push_back(oy);
              idx++;
            end
    return total;
  endfunction

  task automatic prefill(input int n);
    for (int i = 0; i < n; i++) begin
      row_done = 1'b1;
      @(posedge clk); #1;
    end
    row_done = 1'b0;
  endtask

  task automatic run_cfg(input int c, input int w, input int p, input bit periodic,
                         input int rmode, input bit nobubble, input bit poke);
    int pw, total, sent, start_cyc;
    bit got_done;
    pw = w + 2 * p;
    salt = $urandom;
    IFM_C = 8'(c); IFM_W = 8'(w); padding = p[0];
    rows_base = rows_total;
    beats = 0; first_acc = -1; last_acc = -1;
    total = build_exp(c, w, p);
    ready_mode = rmode;
    if (!periodic) prefill(pw);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    got_done = 0;
    for (int k = 1; k <= 20000; k++) begin
      if (done) begin got_done = 1; break; end
      if (poke && k == 5) begin start = 1'b1; IFM_W = IFM_W + 8'd1; end
      else start = 1'b0;
      row_done = periodic && (sent < pw) && (k % 20 == 0);
      if (row_done) sent++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    row_done = 1'b0;
    $display("run C=%0d W=%0d pad=%0d periodic=%0b ready_mode=%0d beats=%0d", c, w, p, periodic, rmode, beats);
    chk("done_seen", got_done, 1);
    if (got_done) begin
      chk("busy_at_done", busy, 0);
      if (total > 0) chk("done_timing", cyc, last_acc + 1);
      else           chk("done_cycle", cyc - start_cyc, 2);
    end
    chk("beat_count", beats, total);
    chk("reads_left", exp_addr.size(), 0);
    if (nobubble) chk("no_bubble", last_acc - first_acc, total - 1);
    @(posedge clk); #1;
    chk("done_single", done, 0);
    ready_mode = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; IFM_C = 8'd16; IFM_W = 8'd4; padding = 1'b1; row_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_last", bus.last_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cfg(16, 4, 1, 0, 0, 1, 0);   // prefilled, full rate
    run_cfg(16, 4, 1, 1, 0, 0, 0);   // row pulses every 20 cycles
    run_cfg(16, 4, 1, 0, 1, 0, 1);   // random backpressure, stray start
    run_cfg(32, 3, 0, 1, 0, 0, 0);   // PW=3, gated
    run_cfg(32, 3, 0, 0, 0, 1, 0);   // PW=3, prefilled
    run_cfg(16, 1, 0, 0, 0, 0, 0);   // PW=1: empty stream

    // reset in the middle of READ with two words buffered
    salt = $urandom;
    IFM_C = 8'd16; IFM_W = 8'd4; padding = 1'b1;
    rows_base = rows_total;
    beats = 0;
    n = build_exp(16, 4, 1);
    ready_mode = 2;
    prefill(6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.valid_out, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_valid", bus.valid_out, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rd_en", bus.rd_en, 0);
    exp_data.delete(); exp_last.delete(); exp_addr.delete(); exp_oy.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    run_cfg(16, 4, 1, 1, 0, 0, 0);   // gating proves rows were cleared
    run_cfg(16, 4, 1, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) begin
      run_cfg(16 * $urandom_range(1, 3), $urandom_range(1, 5), $urandom_range(0, 1),
              1'($urandom_range(0, 1)), $urandom_range(0, 1), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
